// File: rtl/frame_counter.sv
// Frame beat counter: counts valid beats in RUN up to a loaded threshold and
// either parks in FULL (one-shot) or wraps to zero (continuous), pulsing frame_done.
module frame_counter #(
    parameter int CNT_W = 8,
    parameter int MODE  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] thresh,
    input  logic             start,
    input  logic             stop,
    input  logic             clr,
    input  logic             valid,
    output logic [CNT_W-1:0] count,
    output logic             not_zero,
    output logic             full,
    output logic             busy,
    output logic             frame_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam bit               WRAP     = (MODE == 1);

    state_t           state_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] thresh_r;
    logic             frame_done_r;
    logic             start_ok_s;
    logic             terminal_s;

    // A start with a zero threshold is treated as if start were low.
    assign start_ok_s = start && (thresh != CNT_ZERO);
    // thresh_r is never zero in RUN, so thresh_r - 1 cannot underflow there.
    assign terminal_s = (state_r == ST_RUN) && valid && (count_r == (thresh_r - CNT_ONE));

    // Frame state machine: priority clr > stop > start > valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            count_r      <= CNT_ZERO;
            thresh_r     <= CNT_ZERO;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            if (clr) begin
                state_r <= ST_IDLE;
                count_r <= CNT_ZERO;
            end else if (stop) begin
                state_r <= ST_IDLE;
            end else if (start_ok_s) begin
                state_r  <= ST_RUN;
                count_r  <= CNT_ZERO;
                thresh_r <= thresh;
            end else begin
                case (state_r)
                    ST_RUN: begin
                        if (terminal_s) begin
                            frame_done_r <= 1'b1;
                            if (WRAP) begin
                                count_r <= CNT_ZERO;
                            end else begin
                                count_r <= thresh_r;
                                state_r <= ST_FULL;
                            end
                        end else if (valid) begin
                            count_r <= count_r + CNT_ONE;
                        end else begin
                            count_r <= count_r;
                        end
                    end
                    ST_IDLE: state_r <= ST_IDLE;
                    ST_FULL: state_r <= ST_FULL;
                    default: begin
                        state_r <= ST_IDLE;
                        count_r <= CNT_ZERO;
                    end
                endcase
            end
        end
    end

    assign count      = count_r;
    assign frame_done = frame_done_r;
    assign not_zero   = (count_r != CNT_ZERO);
    assign full       = (state_r == ST_FULL);
    assign busy       = (state_r == ST_RUN);

endmodule

// File: tb/tb_frame_counter.sv
// Self-checking bench for frame_counter: one-shot and continuous instances share
// stimulus; table vectors and hand sequences feed an expected-result queue.
module tb_frame_counter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] thresh;
    logic         start, stop, clr, valid;
    logic [W-1:0] count0, count1;
    logic         nz0, nz1, full0, full1, busy0, busy1, done0, done1;

    frame_counter #(.CNT_W(W), .MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .thresh(thresh), .start(start), .stop(stop),
        .clr(clr), .valid(valid), .count(count0), .not_zero(nz0), .full(full0),
        .busy(busy0), .frame_done(done0)
    );

    frame_counter #(.CNT_W(W), .MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .thresh(thresh), .start(start), .stop(stop),
        .clr(clr), .valid(valid), .count(count1), .not_zero(nz1), .full(full1),
        .busy(busy1), .frame_done(done1)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        tag;
        bit           sel;
        bit           st, sp, cl, va;
        logic [W-1:0] th;
        logic [W-1:0] c;
        bit           nz, full, busy, done;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(string tag, bit sel, bit st, bit sp, bit cl, bit va,
                                int th, int c, bit busy, bit full, bit done);
        vec_t v;
        v.tag = tag; v.sel = sel; v.st = st; v.sp = sp; v.cl = cl; v.va = va;
        v.th = W'(th); v.c = W'(c); v.nz = (c != 0);
        v.busy = busy; v.full = full; v.done = done;
        return v;
    endfunction

    task automatic compare_next();
        vec_t         e;
        logic [W+3:0] act, req;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty: no expected entry queued");
        end else begin
            e   = exp_q.pop_front();
            act = e.sel ? {count1, nz1, full1, busy1, done1} : {count0, nz0, full0, busy0, done0};
            req = {e.c, e.nz, e.full, e.busy, e.done};
            if (act !== req) begin
                failures++;
                $display("FAIL %s: got count=%0d nz=%0b full=%0b busy=%0b done=%0b, expected count=%0d nz=%0b full=%0b busy=%0b done=%0b",
                         e.tag, act[W+3:4], act[3], act[2], act[1], act[0],
                         e.c, e.nz, e.full, e.busy, e.done);
            end
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        start = v.st; stop = v.sp; clr = v.cl; valid = v.va; thresh = v.th;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        compare_next();
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({count0, count1, nz0, nz1, full0, full1, busy0, busy1, done0, done1} !== '0) begin
            failures++;
            $display("FAIL %s: got count0=%0d count1=%0d nz=%0b%0b full=%0b%0b busy=%0b%0b done=%0b%0b, expected all zero",
                     tag, count0, count1, nz0, nz1, full0, full1, busy0, busy1, done0, done1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc[7] = '{1, 2, 0, 1, 2, 0, 1};

        // one-shot thresh=5, valid held high
        tbl.push_back(mk("A_clr",   0, 0, 0, 1, 0, 5, 0, 0, 0, 0));
        tbl.push_back(mk("A_start", 0, 1, 0, 0, 1, 5, 0, 1, 0, 0));
        for (int i = 1; i <= 4; i++) tbl.push_back(mk("A_cnt", 0, 0, 0, 0, 1, 5, i, 1, 0, 0));
        tbl.push_back(mk("A_term",  0, 0, 0, 0, 1, 5, 5, 0, 1, 1));
        tbl.push_back(mk("A_hold1", 0, 0, 0, 0, 1, 5, 5, 0, 1, 0));
        tbl.push_back(mk("A_hold2", 0, 0, 0, 0, 1, 5, 5, 0, 1, 0));
        // continuous thresh=3, seven beats
        tbl.push_back(mk("B_clr",   1, 0, 0, 1, 0, 3, 0, 0, 0, 0));
        tbl.push_back(mk("B_start", 1, 1, 0, 0, 0, 3, 0, 1, 0, 0));
        for (int i = 0; i < 7; i++) tbl.push_back(mk("B_cnt", 1, 0, 0, 0, 1, 3, bc[i], 1, 0, bc[i] == 0));
        // gapped valid, then stop at count=2 and restart
        tbl.push_back(mk("C_clr",   0, 0, 0, 1, 0, 8, 0, 0, 0, 0));
        tbl.push_back(mk("C_start", 0, 1, 0, 0, 0, 8, 0, 1, 0, 0));
        tbl.push_back(mk("C_v1",    0, 0, 0, 0, 1, 8, 1, 1, 0, 0));
        tbl.push_back(mk("C_v0",    0, 0, 0, 0, 0, 8, 1, 1, 0, 0));
        tbl.push_back(mk("C_v1b",   0, 0, 0, 0, 1, 8, 2, 1, 0, 0));
        tbl.push_back(mk("C_v0b",   0, 0, 0, 0, 0, 8, 2, 1, 0, 0));
        tbl.push_back(mk("D_stop",  0, 0, 1, 0, 1, 8, 2, 0, 0, 0));
        tbl.push_back(mk("D_restart", 0, 1, 0, 0, 0, 8, 0, 1, 0, 0));
        // zero threshold start ignored
        tbl.push_back(mk("E_clr",    0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("E_start0", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("E_valid",  0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        // stop on the terminal beat
        tbl.push_back(mk("F_clr",   0, 0, 0, 1, 0, 2, 0, 0, 0, 0));
        tbl.push_back(mk("F_start", 0, 1, 0, 0, 0, 2, 0, 1, 0, 0));
        tbl.push_back(mk("F_v",     0, 0, 0, 0, 1, 2, 1, 1, 0, 0));
        tbl.push_back(mk("F_stopterm", 0, 0, 1, 0, 1, 2, 1, 0, 0, 0));
        tbl.push_back(mk("F_after", 0, 0, 0, 0, 0, 2, 1, 0, 0, 0));
        // start on the terminal beat (continuous)
        tbl.push_back(mk("G_clr",   1, 0, 0, 1, 0, 2, 0, 0, 0, 0));
        tbl.push_back(mk("G_start", 1, 1, 0, 0, 0, 2, 0, 1, 0, 0));
        tbl.push_back(mk("G_v",     1, 0, 0, 0, 1, 2, 1, 1, 0, 0));
        tbl.push_back(mk("G_startterm", 1, 1, 0, 0, 1, 2, 0, 1, 0, 0));
        tbl.push_back(mk("G_after", 1, 0, 0, 0, 1, 2, 1, 1, 0, 0));
        // thresh=1 continuous: back-to-back done pulses
        tbl.push_back(mk("H_clr",   1, 0, 0, 1, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk("H_start", 1, 1, 0, 0, 0, 1, 0, 1, 0, 0));
        tbl.push_back(mk("H_t1",    1, 0, 0, 0, 1, 1, 0, 1, 0, 1));
        tbl.push_back(mk("H_t2",    1, 0, 0, 0, 1, 1, 0, 1, 0, 1));
        tbl.push_back(mk("H_idle",  1, 0, 0, 0, 0, 1, 0, 1, 0, 0));
        // clr beats everything
        tbl.push_back(mk("I_clr",   0, 0, 0, 1, 0, 4, 0, 0, 0, 0));
        tbl.push_back(mk("I_start", 0, 1, 0, 0, 0, 4, 0, 1, 0, 0));
        tbl.push_back(mk("I_v",     0, 0, 0, 0, 1, 4, 1, 1, 0, 0));
        tbl.push_back(mk("I_clrall", 0, 1, 1, 1, 1, 4, 0, 0, 0, 0));
        // thresh changes after load are ignored
        tbl.push_back(mk("J_start", 0, 1, 0, 0, 0, 3, 0, 1, 0, 0));
        tbl.push_back(mk("J_v1",    0, 0, 0, 0, 1, 9, 1, 1, 0, 0));
        tbl.push_back(mk("J_v2",    0, 0, 0, 0, 1, 9, 2, 1, 0, 0));
        tbl.push_back(mk("J_term",  0, 0, 0, 0, 1, 9, 3, 0, 1, 1));

        rst_n = 1'b0; start = 1'b0; stop = 1'b0; clr = 1'b0; valid = 1'b0; thresh = '0;
        #3;
        check_all_zero("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // full-scale one-shot frame at thresh=255
        apply(mk("K_clr",   0, 0, 0, 1, 0, 255, 0, 0, 0, 0));
        apply(mk("K_start", 0, 1, 0, 0, 0, 255, 0, 1, 0, 0));
        for (int i = 0; i < 255; i++)
            apply(mk("K_cnt", 0, 0, 0, 0, 1, 255, i + 1, i != 254, i == 254, i == 254));
        apply(mk("K_hold",  0, 0, 0, 0, 1, 255, 255, 0, 1, 0));

        // asynchronous reset mid-frame at count=4
        apply(mk("L_clr",   0, 0, 0, 1, 0, 8, 0, 0, 0, 0));
        apply(mk("L_start", 0, 1, 0, 0, 0, 8, 0, 1, 0, 0));
        for (int i = 1; i <= 4; i++) apply(mk("L_cnt", 0, 0, 0, 0, 1, 8, i, 1, 0, 0));
        @(negedge clk);
        valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        apply(mk("L_noresume", 0, 0, 0, 0, 1, 8, 0, 0, 0, 0));
        apply(mk("L_newstart", 0, 1, 0, 0, 0, 8, 0, 1, 0, 0));
        apply(mk("L_newcnt",   0, 0, 0, 0, 1, 8, 1, 1, 0, 0));

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
